// File: rtl/display_scan.sv
// display_scan: time-multiplexed scan controller for a common-anode,
// active-low seven-segment bank. A snapshot of the hex value is taken
// once per frame. Each digit slot begins with a dark guard interval and
// then drives one anode low. Every output is a flop that is loaded with
// the value implied by the next-cycle state.
module display_scan #(
  parameter int NDIGITS = 8,
  parameter int CLKDIV  = 100000,
  parameter int GUARD   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   d,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   lzs,
  output logic [3:0]             digit,
  output logic [NDIGITS-1:0]     an_n,
  output logic                   dp_n
);

  localparam int CW = (CLKDIV  > 1) ? $clog2(CLKDIV)  : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   sd_q, sd_d;
  logic [NDIGITS-1:0]     sdp_q, sdp_d;
  logic [NDIGITS-1:0]     sblank_q, sblank_d;
  logic                   primed_q, primed_d;
  logic [3:0]             digit_q, digit_d;
  logic [NDIGITS-1:0]     an_n_q, an_n_d;
  logic                   dp_n_q, dp_n_d;

  logic                   wrap;
  logic                   load;
  logic [NDIGITS-1:0]     nz_above;
  logic                   seen_nz;
  logic                   suppress;
  logic                   dark;

  // Prescaler, digit index and snapshot next-state. The snapshot loads on
  // the first edge after reset and again whenever the index wraps to 0.
  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    load     = !primed_q || (wrap && (idx_q == IDX_LAST));
    sd_d     = load ? d     : sd_q;
    sdp_d    = load ? dp    : sdp_q;
    sblank_d = load ? blank : sblank_q;
    primed_d = 1'b1;
  end

  // nz_above[i] is set when any snapshot nibble at position i or higher is
  // nonzero; a digit with nothing nonzero at or above it is a leading zero.
  always_comb begin
    nz_above = '0;
    seen_nz  = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      seen_nz     = seen_nz | (sd_d[4*i +: 4] != 4'h0);
      nz_above[i] = seen_nz;
    end
  end

  // Output values for the next-cycle state, so the flops always agree with
  // cnt/idx/snapshot and the decoder input settles during the guard interval.
  always_comb begin
    digit_d  = sd_d[4*idx_d +: 4];
    suppress = lzs && (idx_d != '0) && !nz_above[idx_d];
    dark     = sblank_d[idx_d] || suppress;
    if ((cnt_d < GUARD_C) || dark || !primed_d) begin
      an_n_d = '1;
      dp_n_d = 1'b1;
    end else begin
      an_n_d = ~(NDIGITS'(1) << idx_d);
      dp_n_d = ~sdp_d[idx_d];
    end
  end

  // All state and output flops; reset forces the dark, unprimed state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sd_q     <= '0;
      sdp_q    <= '0;
      sblank_q <= '0;
      primed_q <= 1'b0;
      digit_q  <= 4'h0;
      an_n_q   <= '1;
      dp_n_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sd_q     <= sd_d;
      sdp_q    <= sdp_d;
      sblank_q <= sblank_d;
      primed_q <= primed_d;
      digit_q  <= digit_d;
      an_n_q   <= an_n_d;
      dp_n_q   <= dp_n_d;
    end
  end

  assign digit = digit_q;
  assign an_n  = an_n_q;
  assign dp_n  = dp_n_q;

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the board's common-anode, active-low seven-segment display bank. It holds a snapshot of an NDIGITS-digit hex value and steps through the digits one at a time. Each step presents one nibble on `digit`, which feeds the hex seven-segment decoder's `a` input, and pulls the matching active-low anode enable. It also provides per-digit blanking, leading-zero suppression, decimal points, and a guard interval between digits that prevents ghosting.

## Interface
- `NDIGITS`, 8: number of digits scanned; 2..16.
- `CLKDIV`, 100000: clock cycles per digit slot; ≥ 4.
- `GUARD`, 16: cycles at the start of each slot with all anodes off; 1 ≤ GUARD < CLKDIV.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `d`  in  4*NDIGITS  hex value; nibble i = `d[4i+3:4i]`, digit 0 is rightmost.
- `dp`  in  NDIGITS  decimal point request per digit, active high.
- `blank`  in  NDIGITS  force digit i dark when bit i = 1.
- `lzs`  in  1  leading-zero suppression enable.
- `digit`  out  4  nibble for the current digit, to the decoder's `a`.
- `an_n`  out  NDIGITS  anode enables, active low; at most one bit low.
- `dp_n`  out  1  decimal point segment, active low.

## Operation
**State**
- Prescaler `cnt`, range 0..CLKDIV-1.
- Digit index `idx`, range 0..NDIGITS-1.
- Snapshot registers `sd`, `sdp`, `sblank`.
- Flag `primed`.

**Snapshot**
- `sd`, `sdp` and `sblank` load from `d`, `dp` and `blank` on the first rising edge after reset release, when `primed` is 0; that edge sets `primed`.
- They also load on every edge where `idx` wraps from NDIGITS-1 to 0.
- At no other time do input changes affect the display, so a frame never tears.

**Scan**
- `cnt` increments each cycle and wraps from CLKDIV-1 to 0.
- On that wrap edge, `idx` advances modulo NDIGITS.
- `idx` 0 maps to anode bit 0.

**Suppression**
- With `lzs` = 1, digit i for i ≥ 1 is suppressed when `sd` nibbles i..NDIGITS-1 are all zero.
- Digit 0 is never suppressed by `lzs`.
- A digit is dark if `sblank[idx]` is 1 or the digit is suppressed.

**Outputs**
- All outputs are driven directly from flops.
- Each output flop loads the value implied by the next-cycle `cnt`, `idx` and snapshot, so outputs always agree with the current state and never glitch.
- `digit` = `sd` nibble at `idx` at all times, including during the guard interval, so the decoder settles before the anode turns on.
- `an_n`: all ones when `cnt` < GUARD, when the digit is dark, or when `primed` = 0. Otherwise bit `idx` is 0 and all other bits are 1.
- `dp_n`: 1 whenever `an_n` is all ones. Otherwise `dp_n` = ~`sdp[idx]`.

## Timing
**Reset values:** `cnt` = 0, `idx` = 0, `sd`/`sdp`/`sblank` = 0, `primed` = 0, `digit` = 0, `an_n` = all ones, `dp_n` = 1.

**After reset release**
- First edge: snapshot loads, `primed` = 1, `cnt` = 1.
- The first anode goes low on the edge where `cnt` becomes GUARD.

**Per slot**
- Each slot is exactly CLKDIV cycles: GUARD cycles dark, then CLKDIV-GUARD cycles lit.
- A full frame is NDIGITS × CLKDIV cycles.
- The input-to-display latency is at most one frame plus one slot.

**Boundary cases**
- Inputs changing on the same edge as the snapshot load are captured with their new values, sampled at that edge.
- Asserting `rst` mid-slot forces all outputs to their reset values immediately, without waiting for a clock edge.
- `blank` = all ones gives `an_n` = all ones for the entire frame.
- With `lzs` = 1 and `sd` = 0, only digit 0 is lit.

## Test plan
Bench parameters: NDIGITS=8, CLKDIV=8, GUARD=2.

1. Reset, then release with `d` = 32'h89AB_CDEF and `lzs` = 0 → `an_n` = 8'hFE first goes low 2 cycles after release with `digit` = 4'hF. Slot k shows nibble k with `an_n` = ~(1<<k) for cycles 2..7 of the slot. The frame repeats every 64 cycles.
2. Change `d` to 32'h0000_0000 in the middle of frame 1 → frame 1 still shows 89ABCDEF. Frame 2 shows all zeros, with the snapshot loaded on the 7→0 wrap.
3. Set `d` = 32'h0000_0120 and `lzs` = 1 → digits 0..2 are lit, showing 0, 2, 1. Digits 3..7 keep `an_n` all ones for their whole slots.
4. Set `blank` = 8'h0F and `dp` = 8'h10 → digits 0..3 are dark. `dp_n` = 0 only during the lit cycles of slot 4; otherwise `dp_n` = 1.
5. Assert `rst` during slot 5, cycle 4 → in the same cycle, without a clock edge, `an_n` = 8'hFF, `dp_n` = 1 and `digit` = 0. After release, scanning restarts at `idx` 0 with a fresh snapshot.
6. Over the whole run, check every cycle: at most one `an_n` bit is low, and `an_n` = 8'hFF during the guard cycles.
